sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 135 +++++++++++++
 tb/tb_sram_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Asynchronous SRAM controller: one access at a time through SETUP, STROBE and HOLD,
// with every SRAM-side pin driven from a flop.
module sram_controller #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              CS,
  output logic              WE,
  output logic              OE,
  output logic              LBS,
  output logic              HBS,
  output logic [ADDR_W-1:0] sram_addr,
  inout  logic [DATA_W-1:0] data
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt, cnt_nx;
  logic                accept;
  logic                capture;

  logic                wr_q, wr_nx;
  logic [1:0]          be_q, be_nx;
  logic [ADDR_W-1:0]   addr_q, addr_nx;
  logic [DATA_W-1:0]   wdata_q, wdata_nx;

  logic                cs_nx, we_nx, oe_nx, lbs_nx, hbs_nx;
  logic                drive_q, drive_nx;
  logic [ADDR_W-1:0]   sram_addr_nx;

  always_comb begin
    accept   = (state == IDLE) && req && (be != 2'b00);
    state_nx = state;
    cnt_nx   = cnt;
    wr_nx    = wr_q;
    be_nx    = be_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;

    if (accept) begin
      wr_nx    = wr;
      be_nx    = be;
      addr_nx  = addr;
      wdata_nx = wdata;
    end

    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = WS;
      end
      STROBE: begin
        if (cnt == '0) state_nx = HOLD;
        else           cnt_nx   = cnt - 4'd1;
      end
      HOLD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Pin values are decoded from the next state and next captured request so the
    // flops present them in the same cycle the FSM enters each phase.
    cs_nx        = 1'b1;
    we_nx        = 1'b1;
    oe_nx        = 1'b1;
    lbs_nx       = 1'b1;
    hbs_nx       = 1'b1;
    drive_nx     = 1'b0;
    sram_addr_nx = sram_addr;
    if (state_nx != IDLE) begin
      cs_nx        = 1'b0;
      lbs_nx       = ~be_nx[0];
      hbs_nx       = ~be_nx[1];
      oe_nx        = wr_nx;
      we_nx        = !(wr_nx && (state_nx == STROBE));
      drive_nx     = wr_nx;
      sram_addr_nx = addr_nx;
    end

    capture = (state == STROBE) && (cnt == '0) && !wr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      CS        <= 1'b1;
      WE        <= 1'b1;
      OE        <= 1'b1;
      LBS       <= 1'b1;
      HBS       <= 1'b1;
      drive_q   <= 1'b0;
      sram_addr <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      wr_q      <= wr_nx;
      be_q      <= be_nx;
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
      CS        <= cs_nx;
      WE        <= we_nx;
      OE        <= oe_nx;
      LBS       <= lbs_nx;
      HBS       <= hbs_nx;
      drive_q   <= drive_nx;
      sram_addr <= sram_addr_nx;
      if (capture) rdata <= data;
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == HOLD);
  assign data  = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: a WAIT_STATES=2 instance with an SRAM model and
// a WAIT_STATES=0 instance exercised with back-to-back writes and changing inputs.
module tb_sram_controller;

  localparam logic [15:0] PROBE = 16'h5A5A;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;

  // WAIT_STATES=2 instance
  logic        req, wr, ready, done, CS, WE, OE, LBS, HBS;
  logic [1:0]  be;
  logic [19:0] addr, sram_addr;
  logic [15:0] wdata, rdata;
  wire  [15:0] data;

  // WAIT_STATES=0 instance
  logic        z_req, z_wr, z_ready, z_done, z_CS, z_WE, z_OE, z_LBS, z_HBS;
  logic [1:0]  z_be;
  logic [19:0] z_addr, z_sram_addr;
  logic [15:0] z_wdata, z_rdata;
  wire  [15:0] z_data;

  always #5 clk = ~clk;

  sram_controller #(.ADDR_W(20), .DATA_W(16), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .be(be), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .CS(CS), .WE(WE), .OE(OE), .LBS(LBS),
    .HBS(HBS), .sram_addr(sram_addr), .data(data)
  );

  sram_controller #(.ADDR_W(20), .DATA_W(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(z_req), .wr(z_wr), .be(z_be), .addr(z_addr),
    .wdata(z_wdata), .ready(z_ready), .done(z_done), .rdata(z_rdata), .CS(z_CS),
    .WE(z_WE), .OE(z_OE), .LBS(z_LBS), .HBS(z_HBS), .sram_addr(z_sram_addr), .data(z_data)
  );

  // SRAM model on the main instance; a probe pattern reveals whether the DUT releases the bus
  logic [15:0] mem [256];
  logic        tb_en, probe_en;
  logic [15:0] tb_val;

  always @(posedge clk) begin
    if (!CS && !WE) begin
      if (!LBS) mem[sram_addr[7:0]][7:0]  <= data[7:0];
      if (!HBS) mem[sram_addr[7:0]][15:8] <= data[15:8];
    end
  end

  always_comb begin
    tb_en  = 1'b0;
    tb_val = '0;
    if (!CS && !OE) begin
      tb_en  = 1'b1;
      tb_val = mem[sram_addr[7:0]];
    end else if (probe_en) begin
      tb_en  = 1'b1;
      tb_val = PROBE;
    end
  end

  assign data = tb_en ? tb_val : 'z;

  typedef struct {logic w; logic [15:0] rd;} exp_t;
  typedef struct {int n; logic [19:0] a; logic [15:0] d; logic [1:0] b;} zexp_t;

  exp_t        sb[$];
  zexp_t       zq[$];
  logic [15:0] shadow [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on the W=2 instance; inputs are scrambled right after the accept edge.
  task automatic access(input logic w, input logic [1:0] b, input logic [19:0] a,
                        input logic [15:0] d, input string tag);
    logic [15:0] rd_exp, bus_exp;
    int n, cs_n, we_n, oe_n, dat_n, sel_bad, addr_bad;
    bit got;
    exp_t e;
    probe_en = 1'b0;
    chk({tag, ":ready"}, ready, 1);
    rd_exp = shadow[a[7:0]];
    if (w) begin
      if (b[0]) shadow[a[7:0]][7:0]  = d[7:0];
      if (b[1]) shadow[a[7:0]][15:8] = d[15:8];
    end
    sb.push_back('{w, rd_exp});
    bus_exp = w ? d : rd_exp;
    req = 1'b1; wr = w; be = b; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; wr = ~w; be = ~b; addr = ~a; wdata = ~d;
    n = 0; cs_n = 0; we_n = 0; oe_n = 0; dat_n = 0; sel_bad = 0; addr_bad = 0; got = 0;
    while (!got && n < 20) begin
      n++;
      if (!CS) cs_n++;
      if (!WE) we_n++;
      if (!OE) oe_n++;
      if (data === bus_exp) dat_n++;
      if (LBS !== ~b[0] || HBS !== ~b[1]) sel_bad++;
      if (sram_addr !== a) addr_bad++;
      if (done) begin
        got = 1;
        e = sb.pop_front();
        if (!e.w) chk({tag, ":rdata"}, rdata, e.rd);
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, ":done_seen"}, got, 1);
    chk({tag, ":latency"}, n, 5);
    chk({tag, ":cs_cycles"}, cs_n, 5);
    chk({tag, ":we_cycles"}, we_n, w ? 3 : 0);
    chk({tag, ":oe_cycles"}, oe_n, w ? 0 : 5);
    chk({tag, ":bus_cycles"}, dat_n, 5);
    chk({tag, ":byte_sel"}, sel_bad, 0);
    chk({tag, ":sram_addr"}, addr_bad, 0);
    @(negedge clk);
    probe_en = 1'b1;
    #1;
    chk({tag, ":idle_pins"}, {ready, done, CS, WE, OE, LBS, HBS}, 7'b1011111);
    chk({tag, ":idle_bus"}, data, PROBE);
  endtask

  initial begin
    int bad, dn, z_bad, z_we, ndone, lat_bad, sp_bad;
    int zacc[$];
    zexp_t ze;

    for (int i = 0; i < 256; i++) shadow[i] = '0;
    reset = 1'b1; probe_en = 1'b1;
    req = 1'b0; wr = 1'b0; be = '0; addr = '0; wdata = '0;
    z_req = 1'b0; z_wr = 1'b0; z_be = '0; z_addr = '0; z_wdata = '0;

    // request held during reset must be dropped
    @(negedge clk);
    req = 1'b1; wr = 1'b1; be = 2'b11; addr = 20'h00055; wdata = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    #1;
    chk("rst:ready_done", {ready, done}, 2'b10);
    chk("rst:strobes", {CS, WE, OE, LBS, HBS}, 5'b11111);
    chk("rst:sram_addr", sram_addr, 0);
    chk("rst:rdata", rdata, 0);
    chk("rst:bus", data, PROBE);
    chk("rst:z_idle", {z_ready, z_CS, z_WE}, 3'b111);
    @(negedge clk);

    access(1'b1, 2'b11, 20'h00010, 16'hA5C3, "wr_full");
    access(1'b0, 2'b11, 20'h00010, 16'h0000, "rd_full");
    access(1'b1, 2'b01, 20'h00010, 16'h1234, "wr_lo");
    access(1'b1, 2'b10, 20'h00010, 16'h7E00, "wr_hi");
    access(1'b0, 2'b01, 20'h00010, 16'h0000, "rd_lo_nomask");
    access(1'b1, 2'b11, 20'hFFF20, 16'hC0DE, "wr_hiaddr");
    access(1'b0, 2'b10, 20'hFFF20, 16'h0000, "rd_hiaddr");

    // be == 00 is never accepted
    req = 1'b1; wr = 1'b1; be = 2'b00; addr = 20'h00077; wdata = 16'hFFFF;
    bad = 0; dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ready || !CS) bad++;
      if (done) dn++;
    end
    req = 1'b0;
    chk("ign:ready_cs", bad, 0);
    chk("ign:done", dn, 0);
    chk("ign:bus", data, PROBE);

    // reset in the second STROBE cycle of a write
    probe_en = 1'b0;
    req = 1'b1; wr = 1'b1; be = 2'b11; addr = 20'h00033; wdata = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid:we_low", WE, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; probe_en = 1'b1;
    #1;
    chk("mid:strobes", {CS, WE, OE, LBS, HBS}, 5'b11111);
    chk("mid:bus", data, PROBE);
    chk("mid:ready_done", {ready, done}, 2'b10);
    chk("mid:sram_addr", sram_addr, 0);
    chk("mid:rdata", rdata, 0);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("mid:no_done", dn, 0);

    access(1'b1, 2'b11, 20'h00040, 16'h0F0F, "post_wr");
    access(1'b0, 2'b11, 20'h00010, 16'h0000, "post_rd");

    // W=0 instance: req held, inputs changing every cycle
    z_req = 1'b1; z_wr = 1'b1;
    z_bad = 0; z_we = 0; ndone = 0; lat_bad = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (!z_CS) begin
        if (zq.size() == 0) z_bad++;
        else if (z_sram_addr !== zq[0].a || z_data !== zq[0].d || z_OE !== 1'b1 ||
                 z_LBS !== ~zq[0].b[0] || z_HBS !== ~zq[0].b[1]) z_bad++;
      end
      if (!z_WE) z_we++;
      if (z_done && zq.size() > 0) begin
        ze = zq.pop_front();
        ndone++;
        if (n - ze.n != 3) lat_bad++;
      end
      z_addr  = 20'($urandom);
      z_wdata = 16'($urandom);
      z_be    = 2'($urandom_range(1, 3));
      if (n >= 24) z_req = 1'b0;
      if (z_ready && z_req) begin
        zq.push_back('{n, z_addr, z_wdata, z_be});
        zacc.push_back(n);
      end
    end
    sp_bad = 0;
    for (int i = 1; i < zacc.size(); i++)
      if (zacc[i] - zacc[i-1] != 4) sp_bad++;
    chk("w0:accepts", zacc.size(), 6);
    chk("w0:dones", ndone, zacc.size());
    chk("w0:latency", lat_bad, 0);
    chk("w0:spacing", sp_bad, 0);
    chk("w0:we_cycles", z_we, zacc.size());
    chk("w0:pins_stable", z_bad, 0);
    chk("w0:drained", zq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
